// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with memory-wait timeout supervision.
// Define MIPS_MC_CTRL_TRAP_EN to vector illegal instructions through TRAP instead of halting.
module mips_mc_control #(
    parameter int ALU_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [5:0]       op_in,
    input  logic [5:0]       func_in,
    input  logic             zero_in,
    input  logic             mem_ready_in,
    output logic             irWrite_out,
    output logic             pcWrite_out,
    output logic             iorD_out,
    output logic             memRead_out,
    output logic             memWrite_out,
    output logic             memToReg_out,
    output logic             regDst_out,
    output logic             regWrite_out,
    output logic             ALUSrcA_out,
    output logic             extCntrl_out,
    output logic [1:0]       ALUSrcB_out,
    output logic [1:0]       pcSrc_out,
    output logic [ALU_W-1:0] ALUCntrl_out,
    output logic [3:0]       state_out,
    output logic             timeout_out
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
`ifdef MIPS_MC_CTRL_TRAP_EN
        TRAP   = 4'd10,
`endif
        HALT   = 4'd11
    } state_t;

`ifdef MIPS_MC_CTRL_TRAP_EN
    localparam state_t ILLEGAL_DEST = TRAP;
`else
    localparam state_t ILLEGAL_DEST = HALT;
`endif

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    // The last held cycle is the one on which the count of waited cycles reaches WAIT_MAX.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'b0110);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4'b0111);
    localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(4'b1000);
    localparam logic [ALU_W-1:0] ALU_SRL = ALU_W'(4'b1001);
    localparam logic [ALU_W-1:0] ALU_LUI = ALU_W'(4'b1111);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               held;
    logic               timeout_hit;
    logic               wait_expired;
    logic               func_legal;
    logic [ALU_W-1:0]   func_alu;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            timeout_out <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= held ? wait_cnt + 1'b1 : '0;
            timeout_out <= timeout_out | timeout_hit;
        end
    end

    always_comb begin
        func_legal = 1'b1;
        func_alu   = ALU_ADD;
        case (func_in)
            6'h00:   func_alu = ALU_SLL;
            6'h02:   func_alu = ALU_SRL;
            6'h20:   func_alu = ALU_ADD;
            6'h22:   func_alu = ALU_SUB;
            6'h24:   func_alu = ALU_AND;
            6'h25:   func_alu = ALU_OR;
            6'h2A:   func_alu = ALU_SLT;
            default: func_legal = 1'b0;
        endcase
    end

    // A ready arriving on the last allowed cycle counts as completion, not timeout.
    assign wait_expired = !mem_ready_in && (wait_cnt == WAIT_LAST);

    always_comb begin
        next_state   = state;
        held         = 1'b0;
        timeout_hit  = 1'b0;
        irWrite_out  = 1'b0;
        pcWrite_out  = 1'b0;
        iorD_out     = 1'b0;
        memRead_out  = 1'b0;
        memWrite_out = 1'b0;
        memToReg_out = 1'b0;
        regDst_out   = 1'b0;
        regWrite_out = 1'b0;
        ALUSrcA_out  = 1'b0;
        extCntrl_out = 1'b0;
        ALUSrcB_out  = 2'b00;
        pcSrc_out    = 2'b00;
        ALUCntrl_out = ALU_ADD;

        case (state)
            FETCH: begin
                memRead_out = 1'b1;
                ALUSrcB_out = 2'b01;
                irWrite_out = mem_ready_in;
                pcWrite_out = mem_ready_in;
                if (mem_ready_in) begin
                    next_state = DECODE;
                end else if (wait_expired) begin
                    next_state  = HALT;
                    timeout_hit = 1'b1;
                end else begin
                    held = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcB_out  = 2'b11;
                extCntrl_out = 1'b1;
                case (op_in)
                    OP_RTYPE:                                  next_state = func_legal ? EXEC : ILLEGAL_DEST;
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LUI: next_state = EXEC;
                    OP_LW, OP_SW:                              next_state = MEMADR;
                    OP_BEQ, OP_BNE:                            next_state = BRANCH;
                    OP_J:                                      next_state = JUMP;
                    default:                                   next_state = ILLEGAL_DEST;
                endcase
            end
            EXEC: begin
                ALUSrcA_out = 1'b1;
                next_state  = ALUWB;
                if (op_in == OP_RTYPE) begin
                    ALUCntrl_out = func_alu;
                end else begin
                    ALUSrcB_out = 2'b10;
                    case (op_in)
                        OP_SUBI: begin ALUCntrl_out = ALU_SUB; extCntrl_out = 1'b1; end
                        OP_ANDI: ALUCntrl_out = ALU_AND;
                        OP_ORI:  ALUCntrl_out = ALU_OR;
                        OP_LUI:  ALUCntrl_out = ALU_LUI;
                        default: begin ALUCntrl_out = ALU_ADD; extCntrl_out = 1'b1; end
                    endcase
                end
            end
            ALUWB: begin
                regWrite_out = 1'b1;
                regDst_out   = (op_in == OP_RTYPE);
                next_state   = FETCH;
            end
            MEMADR: begin
                ALUSrcA_out  = 1'b1;
                ALUSrcB_out  = 2'b10;
                extCntrl_out = 1'b1;
                next_state   = (op_in == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memRead_out = 1'b1;
                iorD_out    = 1'b1;
                if (mem_ready_in) begin
                    next_state = MEMWB;
                end else if (wait_expired) begin
                    next_state  = HALT;
                    timeout_hit = 1'b1;
                end else begin
                    held = 1'b1;
                end
            end
            MEMWB: begin
                regWrite_out = 1'b1;
                memToReg_out = 1'b1;
                next_state   = FETCH;
            end
            MEMWR: begin
                memWrite_out = 1'b1;
                iorD_out     = 1'b1;
                if (mem_ready_in) begin
                    next_state = FETCH;
                end else if (wait_expired) begin
                    next_state  = HALT;
                    timeout_hit = 1'b1;
                end else begin
                    held = 1'b1;
                end
            end
            BRANCH: begin
                ALUSrcA_out  = 1'b1;
                ALUCntrl_out = ALU_SUB;
                pcSrc_out    = 2'b01;
                pcWrite_out  = (op_in == OP_BNE) ? !zero_in : zero_in;
                next_state   = FETCH;
            end
            JUMP: begin
                pcSrc_out   = 2'b10;
                pcWrite_out = 1'b1;
                next_state  = FETCH;
            end
`ifdef MIPS_MC_CTRL_TRAP_EN
            TRAP: begin
                pcSrc_out   = 2'b10;
                pcWrite_out = 1'b1;
                next_state  = FETCH;
            end
`endif
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase

        // During reset the FSM sits in FETCH, but must not load IR/PC from a stale ready.
        if (!reset_n_in) begin
            irWrite_out = 1'b0;
            pcWrite_out = 1'b0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: instruction vector table plus wait/timeout/reset sequences.
module tb_mips_mc_control;

    logic       clk_in = 1'b0;
    logic       reset_n_in;
    logic [5:0] op_in;
    logic [5:0] func_in;
    logic       zero_in;
    logic       mem_ready_in;
    logic       irWrite_out, pcWrite_out, iorD_out, memRead_out, memWrite_out;
    logic       memToReg_out, regDst_out, regWrite_out, ALUSrcA_out, extCntrl_out;
    logic [1:0] ALUSrcB_out, pcSrc_out;
    logic [3:0] ALUCntrl_out;
    logic [3:0] state_out;
    logic       timeout_out;

    always #5 clk_in = ~clk_in;

    mips_mc_control #(.ALU_W(4), .WAIT_MAX(15)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .op_in(op_in), .func_in(func_in),
        .zero_in(zero_in), .mem_ready_in(mem_ready_in),
        .irWrite_out(irWrite_out), .pcWrite_out(pcWrite_out), .iorD_out(iorD_out),
        .memRead_out(memRead_out), .memWrite_out(memWrite_out), .memToReg_out(memToReg_out),
        .regDst_out(regDst_out), .regWrite_out(regWrite_out), .ALUSrcA_out(ALUSrcA_out),
        .extCntrl_out(extCntrl_out), .ALUSrcB_out(ALUSrcB_out), .pcSrc_out(pcSrc_out),
        .ALUCntrl_out(ALUCntrl_out), .state_out(state_out), .timeout_out(timeout_out)
    );

    // Bit order: irW pcW iorD mRd mWr m2r rDst rW srcA ext srcB[1:0] pcSrc[1:0] alu[3:0]
    logic [17:0] ctl;
    assign ctl = {irWrite_out, pcWrite_out, iorD_out, memRead_out, memWrite_out, memToReg_out,
                  regDst_out, regWrite_out, ALUSrcA_out, extCntrl_out, ALUSrcB_out, pcSrc_out,
                  ALUCntrl_out};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        int          len;
        logic [19:0] path;
        logic [17:0] c2;
        logic [17:0] c3;
        logic [17:0] c4;
        logic [17:0] mask2;
    } vec_t;

    vec_t vecs[$];

    logic [17:0] ctl_fetch, ctl_decode, ctl_reset, ctl_halt, ctl_wb_r, ctl_wb_i;
    logic [17:0] ctl_memadr, ctl_memrd, ctl_memwb, ctl_memwr, ctl_jump;

    function automatic logic [17:0] mk_ctl(input logic irw, input logic pcw, input logic iord,
                                           input logic mrd, input logic mwr, input logic m2r,
                                           input logic rdst, input logic rw, input logic sa,
                                           input logic ext, input logic [1:0] sb,
                                           input logic [1:0] ps, input logic [3:0] alu);
        return {irw, pcw, iord, mrd, mwr, m2r, rdst, rw, sa, ext, sb, ps, alu};
    endfunction

    function automatic logic [17:0] r_exec(input logic [3:0] alu);
        return mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, alu);
    endfunction

    function automatic logic [17:0] i_exec(input logic [3:0] alu, input logic ext);
        return mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, ext, 2'b10, 2'b00, alu);
    endfunction

    function automatic logic [17:0] br_ctl(input logic pcw);
        return mk_ctl(0, pcw, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 4'b0110);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        reset_n_in = 1'b0;
        #2;
        check_output("reset_state", 32'(state_out), 32'd0);
        check_output("reset_timeout", 32'(timeout_out), 32'd0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        op_in        = v.op;
        func_in      = v.func;
        zero_in      = v.zero;
        mem_ready_in = 1'b1;
        #1;
        for (int i = 0; i < v.len; i++) begin
            check_output($sformatf("%s_state%0d", v.name, i), 32'(state_out), 32'(v.path[19-4*i -: 4]));
            case (i)
                0: check_output($sformatf("%s_fetch_ctl", v.name), 32'(ctl), 32'(ctl_fetch));
                1: check_output($sformatf("%s_decode_ctl", v.name), 32'(ctl), 32'(ctl_decode));
                2: check_output($sformatf("%s_ctl2", v.name), 32'(ctl & v.mask2), 32'(v.c2 & v.mask2));
                3: check_output($sformatf("%s_ctl3", v.name), 32'(ctl), 32'(v.c3));
                default: check_output($sformatf("%s_ctl4", v.name), 32'(ctl), 32'(v.c4));
            endcase
            next_cycle();
        end
        check_output($sformatf("%s_back_to_fetch", v.name), 32'(state_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ctl_fetch  = mk_ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);
        ctl_decode = mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 4'b0010);
        ctl_reset  = mk_ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);
        ctl_halt   = mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_wb_r   = mk_ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_wb_i   = mk_ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_memadr = mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00, 4'b0010);
        ctl_memrd  = mk_ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_memwb  = mk_ctl(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_memwr  = mk_ctl(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
        ctl_jump   = mk_ctl(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0010);

        vecs.push_back('{"add",  6'h00, 6'h20, 1'b0, 4, 20'h01270, r_exec(4'b0010), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"sub",  6'h00, 6'h22, 1'b0, 4, 20'h01270, r_exec(4'b0110), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"and",  6'h00, 6'h24, 1'b0, 4, 20'h01270, r_exec(4'b0000), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"or",   6'h00, 6'h25, 1'b0, 4, 20'h01270, r_exec(4'b0001), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"slt",  6'h00, 6'h2A, 1'b0, 4, 20'h01270, r_exec(4'b0111), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"sll",  6'h00, 6'h00, 1'b0, 4, 20'h01270, r_exec(4'b1000), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"srl",  6'h00, 6'h02, 1'b0, 4, 20'h01270, r_exec(4'b1001), ctl_wb_r, 18'h0, 18'h3FFFF});
        vecs.push_back('{"addi", 6'h08, 6'h15, 1'b0, 4, 20'h01270, i_exec(4'b0010, 1'b1), ctl_wb_i, 18'h0, 18'h3FFFF});
        vecs.push_back('{"subi", 6'h0A, 6'h00, 1'b0, 4, 20'h01270, i_exec(4'b0110, 1'b1), ctl_wb_i, 18'h0, 18'h3FFFF});
        vecs.push_back('{"andi", 6'h0C, 6'h00, 1'b0, 4, 20'h01270, i_exec(4'b0000, 1'b0), ctl_wb_i, 18'h0, 18'h3FFFF});
        vecs.push_back('{"ori",  6'h0D, 6'h00, 1'b0, 4, 20'h01270, i_exec(4'b0001, 1'b0), ctl_wb_i, 18'h0, 18'h3FFFF});
        vecs.push_back('{"lui",  6'h0F, 6'h00, 1'b0, 4, 20'h01270, i_exec(4'b1111, 1'b0), ctl_wb_i, 18'h0, 18'h3FEFF});
        vecs.push_back('{"lw",   6'h23, 6'h00, 1'b0, 5, 20'h01345, ctl_memadr, ctl_memrd, ctl_memwb, 18'h3FFFF});
        vecs.push_back('{"sw",   6'h2B, 6'h00, 1'b0, 4, 20'h01360, ctl_memadr, ctl_memwr, 18'h0, 18'h3FFFF});
        vecs.push_back('{"beq_z1", 6'h04, 6'h00, 1'b1, 3, 20'h01800, br_ctl(1'b1), 18'h0, 18'h0, 18'h3FFFF});
        vecs.push_back('{"beq_z0", 6'h04, 6'h00, 1'b0, 3, 20'h01800, br_ctl(1'b0), 18'h0, 18'h0, 18'h3FFFF});
        vecs.push_back('{"bne_z1", 6'h05, 6'h00, 1'b1, 3, 20'h01800, br_ctl(1'b0), 18'h0, 18'h0, 18'h3FFFF});
        vecs.push_back('{"bne_z0", 6'h05, 6'h00, 1'b0, 3, 20'h01800, br_ctl(1'b1), 18'h0, 18'h0, 18'h3FFFF});
        vecs.push_back('{"jump", 6'h02, 6'h00, 1'b0, 3, 20'h01900, ctl_jump, 18'h0, 18'h0, 18'h3FFFF});

        reset_n_in   = 1'b0;
        op_in        = 6'h00;
        func_in      = 6'h20;
        zero_in      = 1'b0;
        mem_ready_in = 1'b1;
        #2;
        // Ready is high during reset, yet IR/PC writes must stay masked.
        check_output("in_reset_ctl", 32'(ctl), 32'(ctl_reset));
        check_output("in_reset_state", 32'(state_out), 32'd0);
        check_output("in_reset_timeout", 32'(timeout_out), 32'd0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        #1;

        foreach (vecs[k]) apply_stimulus(vecs[k]);

        // lw with three not-ready cycles in MEMRD
        op_in = 6'h23; mem_ready_in = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        mem_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready_in = 1'b1;
            #1;
            check_output($sformatf("lw_wait_state%0d", i), 32'(state_out), 32'd4);
            check_output($sformatf("lw_wait_ctl%0d", i), 32'(ctl), 32'(ctl_memrd));
            next_cycle();
        end
        check_output("lw_wait_memwb_state", 32'(state_out), 32'd5);
        check_output("lw_wait_memwb_ctl", 32'(ctl), 32'(ctl_memwb));
        next_cycle();
        check_output("lw_wait_back", 32'(state_out), 32'd0);

        // Ready arriving on the final allowed FETCH cycle completes normally.
        op_in = 6'h02; mem_ready_in = 1'b0;
        for (int i = 0; i < 14; i++) next_cycle();
        check_output("edge_fetch_state", 32'(state_out), 32'd0);
        mem_ready_in = 1'b1;
        next_cycle();
        check_output("edge_decode_state", 32'(state_out), 32'd1);
        check_output("edge_no_timeout", 32'(timeout_out), 32'd0);
        next_cycle(); next_cycle();
        check_output("edge_back", 32'(state_out), 32'd0);

        // Counter must clear between FETCH waits and MEMWR waits.
        op_in = 6'h2B; mem_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        mem_ready_in = 1'b1;
        next_cycle(); next_cycle();
        mem_ready_in = 1'b0;
        next_cycle();
        for (int i = 0; i < 10; i++) next_cycle();
        check_output("clr_memwr_state", 32'(state_out), 32'd6);
        check_output("clr_memwr_ctl", 32'(ctl), 32'(ctl_memwr));
        mem_ready_in = 1'b1;
        next_cycle();
        check_output("clr_back", 32'(state_out), 32'd0);
        check_output("clr_no_timeout", 32'(timeout_out), 32'd0);

        // FETCH timeout
        mem_ready_in = 1'b0;
        for (int i = 0; i < 14; i++) next_cycle();
        check_output("to_pre_state", 32'(state_out), 32'd0);
        check_output("to_pre_flag", 32'(timeout_out), 32'd0);
        next_cycle();
        check_output("to_state", 32'(state_out), 32'd11);
        check_output("to_flag", 32'(timeout_out), 32'd1);
        check_output("to_halt_ctl", 32'(ctl), 32'(ctl_halt));
        mem_ready_in = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        check_output("to_halt_sticky", 32'(state_out), 32'd11);
        check_output("to_flag_sticky", 32'(timeout_out), 32'd1);
        apply_reset();

        // Illegal opcode and illegal R-type function
        for (int k = 0; k < 2; k++) begin
            op_in   = (k == 0) ? 6'h3F : 6'h00;
            func_in = 6'h3F;
            mem_ready_in = 1'b1;
            next_cycle(); next_cycle();
`ifdef MIPS_MC_CTRL_TRAP_EN
            check_output($sformatf("illegal%0d_trap_state", k), 32'(state_out), 32'd10);
            check_output($sformatf("illegal%0d_trap_ctl", k), 32'(ctl), 32'(ctl_jump));
            next_cycle();
            check_output($sformatf("illegal%0d_back", k), 32'(state_out), 32'd0);
`else
            check_output($sformatf("illegal%0d_halt_state", k), 32'(state_out), 32'd11);
            check_output($sformatf("illegal%0d_halt_ctl", k), 32'(ctl), 32'(ctl_halt));
            next_cycle();
            check_output($sformatf("illegal%0d_halt_stays", k), 32'(state_out), 32'd11);
            check_output($sformatf("illegal%0d_no_timeout", k), 32'(timeout_out), 32'd0);
            apply_reset();
`endif
        end

        // Reset asserted in the middle of a store aborts it immediately.
        op_in = 6'h2B; func_in = 6'h00; mem_ready_in = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        #1;
        check_output("rst_mid_memwr_state", 32'(state_out), 32'd6);
        check_output("rst_mid_memwr_write", 32'(memWrite_out), 32'd1);
        reset_n_in = 1'b0;
        #1;
        check_output("rst_mid_write_drop", 32'(memWrite_out), 32'd0);
        check_output("rst_mid_state", 32'(state_out), 32'd0);
        check_output("rst_mid_ctl", 32'(ctl), 32'(ctl_reset));
        @(negedge clk_in);
        reset_n_in = 1'b1;
        #1;
        check_output("rst_release_state", 32'(state_out), 32'd0);
        next_cycle();
        check_output("rst_first_edge_decode", 32'(state_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
